// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary scheduler.
package bcd_pkg;

    localparam int N_DIG_DEF = 4;
    localparam int W_DEF     = 16;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_bin_sched_mac_diez.sv
// Multiply-by-ten-and-add step of the digit-serial conversion:
// out = in*10 + digit, built from two shifts so no multiplier is inferred.
module mac_diez #(
    parameter int W = 16
) (
    input  logic [W-1:0] in_val,
    input  logic [3:0]   digit,
    output logic [W-1:0] out_val
);

    assign out_val = (in_val << 3) + (in_val << 1) + {{(W-4){1'b0}}, digit};

endmodule

// File: rtl/bcd_bin_sched.sv
// Round-robin scheduler sharing one digit-serial BCD-to-binary engine
// between operand A and operand B.
// Optional build macro BCD_SCHED_ERR_EN: when defined, nibbles > 9 raise
// err_out with the result; when undefined err_out is tied low and the
// error-flag registers are absent.
//
// state | meaning
// IDLE  | waiting for a request; grants are issued combinationally here
// ITER  | one digit per cycle, most significant first, N_DIG cycles
// DONE  | result presented for one cycle; round-robin pointer updated
module bcd_bin_sched
    import bcd_pkg::*;
#(
    parameter int N_DIG = N_DIG_DEF,
    parameter int W     = W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_a,
    input  logic [4*N_DIG-1:0] bcd_a,
    input  logic               req_b,
    input  logic [4*N_DIG-1:0] bcd_b,
    output logic               gnt_a,
    output logic               gnt_b,
    output logic               busy,
    output logic               valid_out,
    output logic               id_out,
    output logic [W-1:0]       num_bin,
    output logic               err_out
);

    localparam int            CW       = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(N_DIG - 1);

    state_t               state_q;
    logic [W-1:0]         acc_q;
    logic [4*N_DIG-1:0]   bcd_q;
    logic [CW-1:0]        cnt_q;
    logic                 id_q;
    logic                 last_id_q;
    logic                 valid_q;
    logic                 id_out_q;
    logic [W-1:0]         num_bin_q;

    logic [3:0]           nib;
    logic [W-1:0]         acc_d;
    logic                 gnt_a_w;
    logic                 gnt_b_w;

    assign nib = bcd_q[{cnt_q, 2'b00} +: 4];

    mac_diez #(.W(W)) u_mac (
        .in_val  (acc_q),
        .digit   (nib),
        .out_val (acc_d)
    );

    // Round-robin grant, only offered while idle; masked during reset so
    // every output reads 0 while rst is high.
    always_comb begin
        gnt_a_w = 1'b0;
        gnt_b_w = 1'b0;
        if (!rst && state_q == IDLE) begin
            if (req_a && req_b) begin
                if (last_id_q == ID_B) gnt_a_w = 1'b1;
                else                   gnt_b_w = 1'b1;
            end else if (req_a) begin
                gnt_a_w = 1'b1;
            end else if (req_b) begin
                gnt_b_w = 1'b1;
            end
        end
    end

    // Conversion FSM with registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            id_q      <= ID_A;
            last_id_q <= ID_B;
            valid_q   <= 1'b0;
            id_out_q  <= 1'b0;
            num_bin_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_a_w || gnt_b_w) begin
                        bcd_q   <= gnt_a_w ? bcd_a : bcd_b;
                        id_q    <= gnt_a_w ? ID_A : ID_B;
                        acc_q   <= '0;
                        cnt_q   <= CNT_INIT;
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) begin
                        num_bin_q <= acc_d;
                        id_out_q  <= id_q;
                        valid_q   <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    last_id_q <= id_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BCD_SCHED_ERR_EN
    logic err_q;
    logic err_out_q;
    logic err_d;

    assign err_d = err_q | (nib > 4'd9);

    // Sticky invalid-nibble flag, published alongside the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            if (state_q == IDLE && (gnt_a_w || gnt_b_w)) begin
                err_q <= 1'b0;
            end else if (state_q == ITER) begin
                err_q <= err_d;
                if (cnt_q == '0) err_out_q <= err_d;
            end
        end
    end

    assign err_out = err_out_q;
`else
    assign err_out = 1'b0;
`endif

    assign gnt_a     = gnt_a_w;
    assign gnt_b     = gnt_b_w;
    assign busy      = (state_q != IDLE);
    assign valid_out = valid_q;
    assign id_out    = id_out_q;
    assign num_bin   = num_bin_q;

endmodule
